lcd_bus_receiver: RTL

Passive receiver for the HD44780-style character-LCD bus (LCD_DATA/LCD_RS/LCD_RW/LCD_EN) driven by `lcd_controller`. It is the far end of that bus: it decodes each EN strobe into a command or character write, tracks the DDRAM address counter, and mirrors the visible 2×16 screen into a 32-entry character buffer. It serves as an on-chip loopback checker and as a status source for other blocks, which read back what the LCD message driver displayed.

---
 rtl/lcd_bus_receiver_if.sv | 22 ++
 rtl/lcd_bus_receiver.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_receiver_if.sv
// lcd_bus_receiver_if: HD44780-style character-LCD bus bundle.
// master drives DATA/RS/RW/EN; slave (the receiver) only observes them.
interface lcd_bus_receiver_if;
    logic [7:0] LCD_DATA;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;

    modport master (
        output LCD_DATA,
        output LCD_RS,
        output LCD_RW,
        output LCD_EN
    );

    modport slave (
        input LCD_DATA,
        input LCD_RS,
        input LCD_RW,
        input LCD_EN
    );
endinterface

// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver: passive far end of the character-LCD bus. Decodes EN strobes
// into commands/characters, tracks the DDRAM address counter and mirrors the
// visible 2x16 screen into a 32-entry buffer.
// Ports: iCLK/iRST_N (async active-low), bus (slave modport: DATA/RS/RW/EN),
// iRD_ADDR -> oRD_CHAR (registered readout), oCMD_VALID/oCMD, oCHAR_VALID/
// oCHAR/oCHAR_ADDR, oCURSOR (AC), oDISP_ON, oFRAME_DONE, oERR.
module lcd_bus_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_EN_HIGH = 4
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    lcd_bus_receiver_if.slave   bus,
    input  logic [4:0]          iRD_ADDR,
    output logic [7:0]          oRD_CHAR,
    output logic                oCMD_VALID,
    output logic [7:0]          oCMD,
    output logic                oCHAR_VALID,
    output logic [7:0]          oCHAR,
    output logic [4:0]          oCHAR_ADDR,
    output logic [6:0]          oCURSOR,
    output logic                oDISP_ON,
    output logic                oFRAME_DONE,
    output logic                oERR
);

    localparam int CW = $clog2(MIN_EN_HIGH + 1);
    localparam logic [CW-1:0] CNT_MIN = CW'(MIN_EN_HIGH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EN_HI  = 2'd1;
    localparam logic [1:0] S_DECODE = 2'd2;
    localparam logic [1:0] S_CLEAR  = 2'd3;

    // sync bundle: {EN, RS, RW, DATA[7:0]}
    logic [10:0] sync_q [SYNC_STAGES];
    logic        s_en, s_rs, s_rw;
    logic [7:0]  s_dat;

    assign {s_en, s_rs, s_rw, s_dat} = sync_q[SYNC_STAGES-1];

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {bus.LCD_EN, bus.LCD_RS, bus.LCD_RW, bus.LCD_DATA};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    function automatic logic [6:0] ac_inc(input logic [6:0] a);
        if (a == 7'h27)      return 7'h40;
        else if (a == 7'h67) return 7'h00;
        else                 return a + 7'd1;
    endfunction

    function automatic logic [6:0] ac_dec(input logic [6:0] a);
        if (a == 7'h00)      return 7'h67;
        else if (a == 7'h40) return 7'h27;
        else                 return a - 7'd1;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_prev_q;
    logic          rs_q, rs_d;
    logic [7:0]    dat_q, dat_d;
    logic [6:0]    ac_q, ac_d;
    logic          id_q, id_d;
    logic          cg_q, cg_d;
    logic          disp_q, disp_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    char_q, char_d;
    logic [4:0]    caddr_q, caddr_d;
    logic          cmdv_q, cmdv_d;
    logic          charv_q, charv_d;
    logic          frame_q, frame_d;
    logic          err_q, err_d;
    logic [4:0]    clr_q, clr_d;
    logic [7:0]    buf_q [32];
    logic [7:0]    rd_q;
    logic          wr_en;
    logic [4:0]    wr_idx;
    logic [7:0]    wr_dat;

    // Command class decode; one-hot so the decoder below is unique.
    logic c_ddram, c_cgram, c_func, c_shift, c_disp, c_entry, c_home, c_clear;
    always_comb begin
        c_ddram = dat_q[7];
        c_cgram = dat_q[7:6] == 2'b01;
        c_func  = dat_q[7:5] == 3'b001;
        c_shift = dat_q[7:4] == 4'b0001;
        c_disp  = dat_q[7:3] == 5'b00001;
        c_entry = dat_q[7:2] == 6'b000001;
        c_home  = dat_q[7:1] == 7'b0000001;
        c_clear = dat_q == 8'h01;
    end

    // Line 1 is AC 0x00-0x0F, line 2 is AC 0x40-0x4F -> index {AC[6],AC[3:0]}.
    logic       in_win;
    logic [4:0] win_idx;
    assign in_win  = (ac_q[5:4] == 2'b00) && (ac_q[6:4] != 3'b010)
                     && (ac_q[6:4] != 3'b110);
    assign win_idx = {ac_q[6], ac_q[3:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        dat_d   = dat_q;
        ac_d    = ac_q;
        id_d    = id_q;
        cg_d    = cg_q;
        disp_d  = disp_q;
        cmd_d   = cmd_q;
        char_d  = char_q;
        caddr_d = caddr_q;
        clr_d   = clr_q;
        cmdv_d  = 1'b0;
        charv_d = 1'b0;
        frame_d = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_dat  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (s_en) begin
                    state_d = S_EN_HI;
                    cnt_d   = CW'(1);
                end
            end
            S_EN_HI: begin
                if (s_en) begin
                    if (cnt_q < CNT_MIN) cnt_d = cnt_q + CW'(1);
                end else if (s_rw || cnt_q < CNT_MIN) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_DECODE;
                    rs_d    = s_rs;
                    dat_d   = s_dat;
                end
            end
            S_DECODE: begin
                state_d = S_IDLE;
                if (!rs_q) begin
                    cmdv_d = 1'b1;
                    cmd_d  = dat_q;
                    unique case (1'b1)
                        c_ddram: begin
                            ac_d = dat_q[6:0];
                            cg_d = 1'b0;
                        end
                        c_cgram: cg_d = 1'b1;
                        c_func:  ;
                        c_shift: begin
                            if (!dat_q[3])
                                ac_d = dat_q[2] ? ac_inc(ac_q) : ac_dec(ac_q);
                        end
                        c_disp:  disp_d = dat_q[2];
                        c_entry: id_d = dat_q[1];
                        c_home:  ac_d = '0;
                        c_clear: begin
                            ac_d    = '0;
                            id_d    = 1'b1;
                            cg_d    = 1'b0;
                            clr_d   = '0;
                            state_d = S_CLEAR;
                        end
                        default: ;
                    endcase
                end else if (!cg_q) begin
                    if (in_win) begin
                        wr_en   = 1'b1;
                        wr_idx  = win_idx;
                        wr_dat  = dat_q;
                        charv_d = 1'b1;
                        char_d  = dat_q;
                        caddr_d = win_idx;
                        frame_d = (win_idx == 5'd31);
                    end
                    ac_d = id_q ? ac_inc(ac_q) : ac_dec(ac_q);
                end
            end
            S_CLEAR: begin
                wr_en  = 1'b1;
                wr_idx = clr_q;
                wr_dat = 8'h20;
                clr_d  = clr_q + 5'd1;
                if (clr_q == 5'd31) state_d = S_IDLE;
                // strobes finishing while the screen is wiped are lost
                if (en_prev_q && !s_en) err_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            en_prev_q <= 1'b0;
            rs_q      <= 1'b0;
            dat_q     <= '0;
            ac_q      <= '0;
            id_q      <= 1'b1;
            cg_q      <= 1'b0;
            disp_q    <= 1'b0;
            cmd_q     <= '0;
            char_q    <= '0;
            caddr_q   <= '0;
            clr_q     <= '0;
            cmdv_q    <= 1'b0;
            charv_q   <= 1'b0;
            frame_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            en_prev_q <= s_en;
            rs_q      <= rs_d;
            dat_q     <= dat_d;
            ac_q      <= ac_d;
            id_q      <= id_d;
            cg_q      <= cg_d;
            disp_q    <= disp_d;
            cmd_q     <= cmd_d;
            char_q    <= char_d;
            caddr_q   <= caddr_d;
            clr_q     <= clr_d;
            cmdv_q    <= cmdv_d;
            charv_q   <= charv_d;
            frame_q   <= frame_d;
            err_q     <= err_d;
        end
    end

    // Read samples the pre-write contents, so same-cycle read/write gives old data.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
            rd_q <= '0;
        end else begin
            if (wr_en) buf_q[wr_idx] <= wr_dat;
            rd_q <= buf_q[iRD_ADDR];
        end
    end

    assign oRD_CHAR    = rd_q;
    assign oCMD_VALID  = cmdv_q;
    assign oCMD        = cmd_q;
    assign oCHAR_VALID = charv_q;
    assign oCHAR       = char_q;
    assign oCHAR_ADDR  = caddr_q;
    assign oCURSOR     = ac_q;
    assign oDISP_ON    = disp_q;
    assign oFRAME_DONE = frame_q;
    assign oERR        = err_q;

endmodule
